muldiv_iterative_unit: RTL and testbench

- Parametrised, multi-cycle RV32M/RV64M execution unit. Sits beside the single-cycle ALU in the EX stage.
- Takes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU off the combinational path using a radix-2 shift-add / restoring-divide datapath.
- Adds a valid/ready handshake, a destination tag, and pipeline-flush abort.
- Implements ISA-exact divide-by-zero and signed-overflow results, which the combinational ALU does not.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_step.sv | 43 ++++
 rtl/muldiv_iterative_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_iterative_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - funct3 encodings of the RV32M/RV64M operations
//   - FSM state encoding
//   - md_magnitude(): absolute value of a possibly signed operand
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // Widest supported XLEN; md_magnitude works at this width and the
    // caller truncates back to its own XLEN.
    localparam int MAX_XLEN = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIXUP,
        ST_DONE
    } md_state_t;

    // Two's-complement negation modulo 2^MAX_XLEN also gives the correct
    // low XLEN bits for a zero-extended narrower operand.
    function automatic logic [MAX_XLEN-1:0] md_magnitude(input logic [MAX_XLEN-1:0] v,
                                                         input logic is_neg);
        return is_neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration.
//   mode_div_i  0 = shift-add multiply, 1 = restoring divide
//   acc_i/o     multiply: {partial product, remaining multiplier}
//               divide:   low half = dividend bits shifting out / quotient
//                         bits shifting in (LSB left 0 here, see q_o)
//   rem_i/o     divide partial remainder (always < divisor)
//   operand_i   multiplicand / divisor magnitude
//   q_o         quotient bit produced by this iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                mode_div_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     rem_i,
    input  logic [XLEN-1:0]     operand_i,
    output logic [2*XLEN-1:0]   acc_o,
    output logic [XLEN-1:0]     rem_o,
    output logic                q_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    always_comb begin
        // Carry out of the add lands in the MSB before the right shift.
        sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        // Trial remainder needs XLEN+1 bits: 2*rem+bit may exceed 2^XLEN-1.
        trial = {rem_i, acc_i[XLEN-1]};
        diff  = trial - {1'b0, operand_i};
        acc_o = acc_i;
        rem_o = rem_i;
        q_o   = 1'b0;
        if (mode_div_i) begin
            q_o   = ~diff[XLEN];
            rem_o = q_o ? diff[XLEN-1:0] : trial[XLEN-1:0];
            acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], 1'b0};
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iterative_unit.sv
// muldiv_iterative_unit: multi-cycle RV32M/RV64M multiply/divide unit.
//   CLK/RESET      clock, synchronous active-high reset
//   FLUSH          abort anything in flight (beats everything but RESET)
//   START/READY    request handshake, with OP/OPERAND1/OPERAND2/TAG_IN
//   RESULT_VALID   RESULT/TAG_OUT valid, held until RESULT_ACK
// Normal ops: IDLE -> PREP -> CALC (XLEN cycles) -> FIXUP -> DONE.
// Divide-by-zero and signed overflow go straight from IDLE to DONE.
module muldiv_iterative_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 FLUSH,
    input  logic                 START,
    output logic                 READY,
    input  logic [2:0]           OP,
    input  logic [XLEN-1:0]      OPERAND1,
    input  logic [XLEN-1:0]      OPERAND2,
    input  logic [TAG_WIDTH-1:0] TAG_IN,
    output logic                 RESULT_VALID,
    input  logic                 RESULT_ACK,
    output logic [XLEN-1:0]      RESULT,
    output logic [TAG_WIDTH-1:0] TAG_OUT
);

    localparam int CNT_W = $clog2(XLEN + 1);

    md_state_t              state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [XLEN-1:0]        a_q, a_d, b_q, b_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [2*XLEN-1:0]      acc_q, acc_d;
    logic [XLEN-1:0]        rem_q, rem_d;
    logic                   neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]        result_q, result_d;

    logic [2*XLEN-1:0]      step_acc;
    logic [XLEN-1:0]        step_rem;
    logic                   step_q;

    logic                   sgn_a, sgn_b, div_zero, div_ovf;
    logic [XLEN-1:0]        mag_a, mag_b, quot, remv;
    logic [2*XLEN-1:0]      prod;

    // b_q holds the divisor/multiplicand magnitude once PREP has run.
    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode_div_i (op_q[2]),
        .acc_i      (acc_q),
        .rem_i      (rem_q),
        .operand_i  (b_q),
        .acc_o      (step_acc),
        .rem_o      (step_rem),
        .q_o        (step_q)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        div_zero = (OPERAND2 == '0);
        div_ovf  = ~OP[0] & (OPERAND1 == {1'b1, {(XLEN-1){1'b0}}}) & (OPERAND2 == '1);

        sgn_a = (op_q == MD_MUL || op_q == MD_MULH || op_q == MD_MULHSU ||
                 op_q == MD_DIV || op_q == MD_REM) & a_q[XLEN-1];
        sgn_b = (op_q == MD_MUL || op_q == MD_MULH ||
                 op_q == MD_DIV || op_q == MD_REM) & b_q[XLEN-1];
        mag_a = XLEN'(md_magnitude(MAX_XLEN'(a_q), sgn_a));
        mag_b = XLEN'(md_magnitude(MAX_XLEN'(b_q), sgn_b));

        prod = neg_res_q ? -acc_q : acc_q;
        quot = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        remv = neg_rem_q ? -rem_q : rem_q;

        case (state_q)
            ST_IDLE: begin
                if (START && !FLUSH) begin
                    op_d  = OP;
                    a_d   = OPERAND1;
                    b_d   = OPERAND2;
                    tag_d = TAG_IN;
                    if (OP[2] && (div_zero || div_ovf)) begin
                        // OP[1] separates REM/REMU from DIV/DIVU.
                        if (div_zero) result_d = OP[1] ? OPERAND1 : '1;
                        else          result_d = OP[1] ? '0 : OPERAND1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PREP;
                    end
                end
            end
            ST_PREP: begin
                acc_d     = {{XLEN{1'b0}}, mag_a};
                rem_d     = '0;
                b_d       = mag_b;
                neg_res_d = sgn_a ^ sgn_b;
                neg_rem_d = sgn_a;
                cnt_d     = CNT_W'(XLEN);
                state_d   = ST_CALC;
            end
            ST_CALC: begin
                // Quotient bit enters at the LSB; zero in multiply mode.
                acc_d = step_acc | {{(2*XLEN-1){1'b0}}, step_q};
                rem_d = step_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                case (op_q)
                    MD_MUL:                       result_d = prod[XLEN-1:0];
                    MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod[2*XLEN-1:XLEN];
                    MD_DIV, MD_DIVU:              result_d = quot;
                    default:                      result_d = remv;
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (RESULT_ACK) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (FLUSH) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign READY        = (state_q == ST_IDLE);
    assign RESULT_VALID = (state_q == ST_DONE);
    assign RESULT       = result_q;
    assign TAG_OUT      = tag_q;

endmodule

// File: tb/tb_muldiv_iterative_unit.sv
module tb_muldiv_iterative_unit;

    logic        CLK = 1'b0;
    logic        RESET, FLUSH, START, RESULT_ACK;
    logic        READY, RESULT_VALID;
    logic [2:0]  OP;
    logic [31:0] OPERAND1, OPERAND2, RESULT;
    logic [4:0]  TAG_IN, TAG_OUT;

    logic        START64, RESULT_ACK64, READY64, RESULT_VALID64;
    logic [2:0]  OP64;
    logic [63:0] A64, B64, RESULT64;
    logic [4:0]  TAG_IN64, TAG_OUT64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    muldiv_iterative_unit #(.XLEN(32), .TAG_WIDTH(5)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .START(START), .READY(READY),
        .OP(OP), .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .TAG_IN(TAG_IN),
        .RESULT_VALID(RESULT_VALID), .RESULT_ACK(RESULT_ACK),
        .RESULT(RESULT), .TAG_OUT(TAG_OUT)
    );

    muldiv_iterative_unit #(.XLEN(64), .TAG_WIDTH(5)) dut64 (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .START(START64), .READY(READY64),
        .OP(OP64), .OPERAND1(A64), .OPERAND2(B64), .TAG_IN(TAG_IN64),
        .RESULT_VALID(RESULT_VALID64), .RESULT_ACK(RESULT_ACK64),
        .RESULT(RESULT64), .TAG_OUT(TAG_OUT64)
    );

    // Reference: ISA semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
        ia = int'(a); ib = int'(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait (bounded) for RESULT_VALID, capture, ACK.
    // lat = cycles after the accept edge; -1 on timeout.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] res, output logic [4:0] tg,
                         output int lat);
        @(negedge CLK);
        START = 1'b1; OP = op; OPERAND1 = a; OPERAND2 = b; TAG_IN = tag;
        @(posedge CLK); #1 START = 1'b0;
        lat = -1; res = '0; tg = '0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLK);
            if (RESULT_VALID) begin lat = c; res = RESULT; tg = TAG_OUT; break; end
        end
        if (lat > 0) begin
            RESULT_ACK = 1'b1;
            @(posedge CLK); #1 RESULT_ACK = 1'b0;
        end
    endtask

    task automatic do_op64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] tag, output logic [63:0] res, output int lat);
        @(negedge CLK);
        START64 = 1'b1; OP64 = op; A64 = a; B64 = b; TAG_IN64 = tag;
        @(posedge CLK); #1 START64 = 1'b0;
        lat = -1; res = '0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge CLK);
            if (RESULT_VALID64) begin lat = c; res = RESULT64; break; end
        end
        if (lat > 0) begin
            RESULT_ACK64 = 1'b1;
            @(posedge CLK); #1 RESULT_ACK64 = 1'b0;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (READY !== 1'b1 || RESULT_VALID !== 1'b0 || RESULT !== 32'h0 || TAG_OUT !== 5'h0) begin
            n_bad++;
            $display("FAIL reset: READY=%b VALID=%b RESULT=%h TAG=%h want 1 0 0 0",
                     READY, RESULT_VALID, RESULT, TAG_OUT);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                  32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                                  32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int          lats[12] = '{35, 35, 35, 35, 35, 35, 35, 35, 1, 1, 1, 1};
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            do_op(ops[i], as[i], bs[i], 5'(i + 3), res, tg, lat);
            n_cmp++;
            if (res !== exp[i] || tg !== 5'(i + 3) || lat != lats[i]) begin
                n_bad++;
                $display("FAIL directed[%0d] op=%0d: result=%h tag=%0d lat=%0d want %h %0d %0d",
                         i, ops[i], res, tg, lat, exp[i], i + 3, lats[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, want;
        logic [4:0]  tag, tg;
        int          lat, wlat;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick_operand(); b = pick_operand();
            tag = 5'($urandom);
            want = ref_md(op, a, b);
            wlat = is_special(op, a, b) ? 1 : 35;
            do_op(op, a, b, tag, res, tg, lat);
            n_cmp++;
            if (res !== want || tg !== tag || lat != wlat) begin
                n_bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h tag=%0d lat=%0d want %h %0d %0d",
                         i, op, a, b, res, tg, lat, want, tag, wlat);
            end
        end
    endtask

    task automatic test_flush();
        bit          seen;
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        // FLUSH with START in IDLE: nothing accepted.
        @(negedge CLK);
        FLUSH = 1'b1; START = 1'b1; OP = 3'd0; OPERAND1 = 32'd2; OPERAND2 = 32'd2; TAG_IN = 5'd1;
        @(posedge CLK); #1 FLUSH = 1'b0; START = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (READY !== 1'b1 || RESULT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_start_idle: READY=%b VALID=%b want 1 0", READY, RESULT_VALID);
        end
        // FLUSH at cycle 10 of a DIV.
        START = 1'b1; OP = 3'd4; OPERAND1 = 32'd1000; OPERAND2 = 32'd7; TAG_IN = 5'd2;
        @(posedge CLK); #1 START = 1'b0;
        repeat (9) @(negedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1;
        @(posedge CLK); #1 FLUSH = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (READY !== 1'b1 || RESULT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_calc: READY=%b VALID=%b want 1 0", READY, RESULT_VALID);
        end
        seen = 1'b0;
        repeat (50) begin @(negedge CLK); if (RESULT_VALID) seen = 1'b1; end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL flush_no_result: RESULT_VALID rose=%b want 0", seen);
        end
        do_op(3'd0, 32'd3, 32'd4, 5'd6, res, tg, lat);
        n_cmp++;
        if (res !== 32'd12 || tg !== 5'd6 || lat != 35) begin
            n_bad++;
            $display("FAIL flush_then_mul: result=%h tag=%0d lat=%0d want c 6 35", res, tg, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge CLK);
        START = 1'b1; OP = 3'd5; OPERAND1 = 32'd100; OPERAND2 = 32'd7; TAG_IN = 5'd9;
        @(posedge CLK); #1 START = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLK);
            if (RESULT_VALID) begin lat = c; break; end
        end
        n_cmp++;
        if (lat != 35) begin
            n_bad++;
            $display("FAIL bp_latency: lat=%0d want 35", lat);
        end
        // Hold ACK low while a competing request sits on START.
        for (int k = 0; k < 5; k++) begin
            START = 1'b1; OP = 3'd0; OPERAND1 = 32'd5; OPERAND2 = 32'd5; TAG_IN = 5'd20;
            @(negedge CLK);
            n_cmp++;
            if (RESULT !== 32'd14 || TAG_OUT !== 5'd9 || READY !== 1'b0 || RESULT_VALID !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: RESULT=%h TAG=%0d READY=%b VALID=%b want e 9 0 1",
                         k, RESULT, TAG_OUT, READY, RESULT_VALID);
            end
        end
        RESULT_ACK = 1'b1;
        @(posedge CLK); #1 RESULT_ACK = 1'b0; START = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (READY !== 1'b1 || RESULT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_ack: READY=%b VALID=%b want 1 0", READY, RESULT_VALID);
        end
    endtask

    task automatic test_flush_ack_done();
        int lat;
        @(negedge CLK);
        START = 1'b1; OP = 3'd7; OPERAND1 = 32'd9; OPERAND2 = 32'd0; TAG_IN = 5'd4;
        @(posedge CLK); #1 START = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (RESULT_VALID) begin lat = c; break; end
        end
        n_cmp++;
        if (lat != 1 || RESULT !== 32'd9) begin
            n_bad++;
            $display("FAIL remu_zero: lat=%0d RESULT=%h want 1 9", lat, RESULT);
        end
        FLUSH = 1'b1; RESULT_ACK = 1'b1;
        @(posedge CLK); #1 FLUSH = 1'b0; RESULT_ACK = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (READY !== 1'b1 || RESULT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_ack_done: READY=%b VALID=%b want 1 0", READY, RESULT_VALID);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge CLK);
        START = 1'b1; OP = 3'd0; OPERAND1 = 32'd11; OPERAND2 = 32'd13; TAG_IN = 5'd17;
        @(posedge CLK); #1 START = 1'b0;
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (READY !== 1'b1 || RESULT_VALID !== 1'b0 || RESULT !== 32'h0 || TAG_OUT !== 5'h0) begin
            n_bad++;
            $display("FAIL reset_mid: READY=%b VALID=%b RESULT=%h TAG=%h want 1 0 0 0",
                     READY, RESULT_VALID, RESULT, TAG_OUT);
        end
        seen = 1'b0;
        repeat (40) begin @(negedge CLK); if (RESULT_VALID) seen = 1'b1; end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL reset_mid_no_result: RESULT_VALID rose=%b want 0", seen);
        end
    endtask

    task automatic test_xlen64();
        logic [63:0] res, a, b;
        int lat;
        do_op64(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, res, lat);
        n_cmp++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFE || lat != 67) begin
            n_bad++;
            $display("FAIL x64_mulhu: result=%h lat=%0d want fffffffffffffffe 67", res, lat);
        end
        for (int i = 0; i < 3; i++) begin
            a = {$urandom, $urandom};
            b = {32'h0, $urandom} | 64'h1;
            do_op64(3'd5, a, b, 5'd2, res, lat);
            n_cmp++;
            if (res !== a / b || lat != 67) begin
                n_bad++;
                $display("FAIL x64_divu[%0d] a=%h b=%h: result=%h lat=%0d want %h 67", i, a, b, res, lat, a / b);
            end
        end
    endtask

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; START = 1'b0; RESULT_ACK = 1'b0;
        OP = '0; OPERAND1 = '0; OPERAND2 = '0; TAG_IN = '0;
        START64 = 1'b0; RESULT_ACK64 = 1'b0; OP64 = '0; A64 = '0; B64 = '0; TAG_IN64 = '0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_backpressure();
        test_flush_ack_done();
        test_reset_mid();
        test_xlen64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
